fifo72_xgmii_arb: RTL and testbench
===================================

FIFO72_XGMII_ARB -- requirements
Module: fifo72_xgmii_arb

Interface
REQ-001 Parameter GAP, 4'h1, number of idle words inserted between a terminate word and the next start word.
REQ-002 xgmii_tx_clk  input  1  single clock for all logic.
REQ-003 sys_rst  input  1  asynchronous, active-high reset.
REQ-004 tx_en  input  1  when low, no new frame is granted; a frame in progress completes.
REQ-005 fifo0_dout, fifo1_dout  input  72 each  requester heads in first-word-fall-through format: [71:64] per-lane control flags, lane i = [8i+7:8i].
REQ-006 fifo0_empty, fifo1_empty  input  1 each  head not valid when high.
REQ-007 fifo0_rd_en, fifo1_rd_en  output  1 each  pop strobe, combinational from state and inputs.
REQ-008 xgmii_txd  output  72  registered XGMII TX word, same format.
REQ-009 grant  output  2  one-hot current owner, registered; 2'b00 when no frame is active.
REQ-010 frame_cnt  output  32  completed frames, wrapping.
REQ-011 underrun_cnt  output  16  aborted frames, saturating at 16'hffff.
REQ-012 drop_cnt  output  16  discarded non-start words, saturating at 16'hffff.

Function
REQ-013 Idle word IDLE_W = 72'hff_07070707_07070707; start word = ctrl[0]=1 and lane0=8'hFB; terminate word = any lane with ctrl=1 and data 8'hFD.
REQ-014 Abort word ABORT_W = 72'hff_07070707_0707FDFE: error in lane0, terminate in lane1.
REQ-015 States: S_IDLE, S_SEND, S_FLUSH, S_GAP; one-hot or binary encoding is an implementation choice.
REQ-016 Requester n is ready when !fifon_empty and its head is a start word.
REQ-017 S_IDLE: xgmii_txd loads IDLE_W unless a grant occurs this cycle.
REQ-018 S_IDLE grant: tx_en=1 and any requester ready; when both are ready, the requester other than last_grant wins (round-robin at frame boundaries).
REQ-019 Grant cycle: winner rd_en=1, xgmii_txd loads the start word at the next edge, grant and last_grant update, state becomes S_SEND.
REQ-020 Grant cycle with the start word also containing terminate: frame_cnt+1, state becomes S_GAP (S_IDLE if GAP=0).
REQ-021 S_IDLE purge: each non-empty, non-granted requester whose head is not a start word is popped that cycle, independent of tx_en.
REQ-022 S_IDLE purge accounting: drop_cnt adds 0, 1 or 2 per cycle and saturates.
REQ-023 S_SEND with owner non-empty: rd_en=1 and the word is passed to xgmii_txd unmodified, one cycle latency.
REQ-024 S_SEND terminate passed: frame_cnt+1, grant becomes 2'b00, state becomes S_GAP (S_IDLE if GAP=0).
REQ-025 S_SEND with owner empty (underrun): rd_en=0, xgmii_txd loads ABORT_W, underrun_cnt+1, state becomes S_FLUSH.
REQ-026 S_FLUSH: xgmii_txd loads IDLE_W and the owner is popped whenever non-empty, words discarded.
REQ-027 S_FLUSH exit: popping a terminate word moves to S_GAP with grant 2'b00; S_FLUSH waits indefinitely; frame_cnt unchanged.
REQ-028 S_GAP: loads IDLE_W for exactly GAP cycles using a 4-bit down-counter, then state becomes S_IDLE.
REQ-029 With a requester ready, exactly GAP IDLE_W words lie between a terminate/abort word and the next start word; GAP=0 gives back-to-back frames.
REQ-030 The non-owner rd_en is 0 in S_SEND, S_FLUSH and S_GAP.
REQ-031 tx_en deasserted mid-frame has no effect until the frame returns to S_IDLE.

Reset
REQ-032 On sys_rst high, asynchronously: xgmii_txd=IDLE_W, grant=2'b00, state S_IDLE, last_grant=1 (requester 0 wins first tie), GAP counter=0, all counters=0.
REQ-033 During reset, both rd_en outputs are 0.
REQ-034 Reset asserted mid-frame truncates the output with no terminate; the FIFO residue is purged later as non-start words per REQ-021.

Verification
REQ-035 Single frame on fifo0, start word plus 3 data words plus a terminate word, GAP=1 -> txd reproduces 5 words 1 cycle after pops, then 1 IDLE_W; frame_cnt=1; grant=01 during the frame.
REQ-036 Both FIFOs hold 2 frames, tx_en=1 -> frame order 0,1,0,1; exactly GAP idles between frames; frame_cnt=4.
REQ-037 fifo1 empties after the start word plus 1 data word, remainder plus terminate arriving 10 cycles later -> ABORT_W emitted; underrun_cnt=1; remainder discarded; 1 idle; frame_cnt unchanged.
REQ-038 fifo0 head holds 3 non-start words, then a frame -> drop_cnt=3 and the frame is sent normally; drop_cnt saturation at 16'hffff is checked by forcing.
REQ-039 tx_en low with both ready -> continuous IDLE_W, no rd_en; raising tx_en grants requester 0 on the next edge; lowering tx_en mid-frame completes the frame.
REQ-040 sys_rst pulse mid-frame -> txd=IDLE_W immediately, grant=00, counters 0; next start arbitration favors requester 0.

Source files
------------

// File: rtl/fifo72_xgmii_arb.sv
// Two-requester XGMII TX arbiter: frame-granular round-robin over FWFT FIFOs,
// underrun abort with flush, fixed post-frame idle gap and non-start purge.
module fifo72_xgmii_arb #(
  parameter logic [3:0] GAP = 4'h1
) (
  input  logic        xgmii_tx_clk,
  input  logic        sys_rst,
  input  logic        tx_en,
  input  logic [71:0] fifo0_dout,
  input  logic [71:0] fifo1_dout,
  input  logic        fifo0_empty,
  input  logic        fifo1_empty,
  output logic        fifo0_rd_en,
  output logic        fifo1_rd_en,
  output logic [71:0] xgmii_txd,
  output logic [1:0]  grant,
  output logic [31:0] frame_cnt,
  output logic [15:0] underrun_cnt,
  output logic [15:0] drop_cnt
);
  localparam logic [71:0] IDLE_W  = 72'hff_07070707_07070707;
  localparam logic [71:0] ABORT_W = 72'hff_07070707_0707fdfe;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_FLUSH, S_GAP} state_t;
  localparam state_t S_AFTER = (GAP == 4'h0) ? S_IDLE : S_GAP;

  state_t      state_q, state_d;
  logic [71:0] txd_q, txd_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_q, last_d;
  logic [3:0]  gap_q, gap_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] underrun_cnt_q, underrun_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  logic [1:0][71:0] head;
  logic [1:0]       empty, is_start, is_term, ready, rd;
  logic             win;
  logic [1:0]       drops;
  logic [16:0]      drop_sum;

  assign head  = {fifo1_dout, fifo0_dout};
  assign empty = {fifo1_empty, fifo0_empty};

  genvar gi, li;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      logic [7:0] lane_term;
      for (li = 0; li < 8; li++) begin : g_lane
        assign lane_term[li] = head[gi][64+li] && (head[gi][8*li +: 8] == 8'hFD);
      end
      assign is_term[gi]  = |lane_term;
      assign is_start[gi] = head[gi][64] && (head[gi][7:0] == 8'hFB);
      assign ready[gi]    = !empty[gi] && is_start[gi];
    end
  endgenerate

  always_comb begin
    state_d        = state_q;
    txd_d          = IDLE_W;
    grant_d        = grant_q;
    last_d         = last_q;
    gap_d          = gap_q;
    frame_cnt_d    = frame_cnt_q;
    underrun_cnt_d = underrun_cnt_q;
    drop_cnt_d     = drop_cnt_q;
    rd             = 2'b00;
    win            = 1'b0;
    drops          = 2'd0;
    drop_sum       = 17'd0;
    case (state_q)
      S_IDLE: begin
        if (tx_en && (ready != 2'b00)) begin
          // On a tie the requester that did not own the previous frame wins.
          win     = (ready == 2'b11) ? ~last_q : ready[1];
          rd[win] = 1'b1;
          txd_d   = head[win];
          grant_d = win ? 2'b10 : 2'b01;
          last_d  = win;
          state_d = S_SEND;
          if (is_term[win]) begin
            frame_cnt_d = frame_cnt_q + 32'd1;
            grant_d     = 2'b00;
            gap_d       = GAP;
            state_d     = S_AFTER;
          end
        end
        for (int i = 0; i < 2; i++) begin
          if (!empty[i] && !is_start[i]) begin
            rd[i] = 1'b1;
            drops = drops + 2'd1;
          end
        end
        drop_sum   = {1'b0, drop_cnt_q} + {15'd0, drops};
        drop_cnt_d = drop_sum[16] ? 16'hffff : drop_sum[15:0];
      end
      S_SEND: begin
        if (!empty[last_q]) begin
          rd[last_q] = 1'b1;
          txd_d      = head[last_q];
          if (is_term[last_q]) begin
            frame_cnt_d = frame_cnt_q + 32'd1;
            grant_d     = 2'b00;
            gap_d       = GAP;
            state_d     = S_AFTER;
          end
        end else begin
          txd_d = ABORT_W;
          if (underrun_cnt_q != 16'hffff) underrun_cnt_d = underrun_cnt_q + 16'd1;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (!empty[last_q]) begin
          rd[last_q] = 1'b1;
          if (is_term[last_q]) begin
            grant_d = 2'b00;
            gap_d   = GAP;
            state_d = S_AFTER;
          end
        end
      end
      S_GAP: begin
        if (gap_q <= 4'd1) begin
          gap_d   = 4'd0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge xgmii_tx_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q        <= S_IDLE;
      txd_q          <= IDLE_W;
      grant_q        <= 2'b00;
      last_q         <= 1'b1;
      gap_q          <= 4'h0;
      frame_cnt_q    <= 32'd0;
      underrun_cnt_q <= 16'd0;
      drop_cnt_q     <= 16'd0;
    end else begin
      state_q        <= state_d;
      txd_q          <= txd_d;
      grant_q        <= grant_d;
      last_q         <= last_d;
      gap_q          <= gap_d;
      frame_cnt_q    <= frame_cnt_d;
      underrun_cnt_q <= underrun_cnt_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  // Pops are suppressed while reset is held so the FIFOs are never drained blind.
  assign fifo0_rd_en  = rd[0] & ~sys_rst;
  assign fifo1_rd_en  = rd[1] & ~sys_rst;
  assign xgmii_txd    = txd_q;
  assign grant        = grant_q;
  assign frame_cnt    = frame_cnt_q;
  assign underrun_cnt = underrun_cnt_q;
  assign drop_cnt     = drop_cnt_q;
endmodule

// File: tb/tb_fifo72_xgmii_arb.sv
// Directed bench for fifo72_xgmii_arb: FWFT FIFO models, output-word scoreboard,
// idle-gap tracking and counter checks around each scenario.
module tb_fifo72_xgmii_arb;
  localparam logic [71:0] IDLE_W  = 72'hff_07070707_07070707;
  localparam logic [71:0] ABORT_W = 72'hff_07070707_0707fdfe;

  logic        clk = 1'b0;
  logic        rst, tx_en;
  logic [71:0] d0, d1, txd;
  logic        e0, e1, rd0, rd1;
  logic [1:0]  grant;
  logic [31:0] frame_cnt;
  logic [15:0] under_cnt, drop_cnt;

  always #5 clk = ~clk;

  fifo72_xgmii_arb #(.GAP(4'h1)) dut (
    .xgmii_tx_clk(clk), .sys_rst(rst), .tx_en(tx_en),
    .fifo0_dout(d0), .fifo1_dout(d1), .fifo0_empty(e0), .fifo1_empty(e1),
    .fifo0_rd_en(rd0), .fifo1_rd_en(rd1), .xgmii_txd(txd), .grant(grant),
    .frame_cnt(frame_cnt), .underrun_cnt(under_cnt), .drop_cnt(drop_cnt)
  );

  // FWFT FIFO models: written by the stimulus, popped on rd_en at the clock edge.
  logic [71:0] mem0 [256];
  logic [71:0] mem1 [256];
  int wp0 = 0, wp1 = 0, rp0 = 0, rp1 = 0;
  assign e0 = (rp0 == wp0);
  assign e1 = (rp1 == wp1);
  assign d0 = mem0[rp0[7:0]];
  assign d1 = mem1[rp1[7:0]];

  always @(posedge clk) begin
    if (rd0 && (rp0 != wp0)) rp0 <= rp0 + 1;
    if (rd1 && (rp1 != wp1)) rp1 <= rp1 + 1;
  end

  typedef struct {
    logic [71:0] w;
    logic [1:0]  g;
    bit          cg;
  } exp_t;

  exp_t exp_q[$];
  int   gaps_q[$];
  int   idle_run = 0;
  bit   mon_en = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] w_start(input logic [7:0] id);
    return {8'h01, id, 48'h1111_2222_3333, 8'hFB};
  endfunction
  function automatic logic [71:0] w_data(input logic [7:0] id, input logic [7:0] k);
    return {8'h00, id, k, 48'ha5a5_5a5a_c3c3};
  endfunction
  function automatic logic [71:0] w_term(input logic [7:0] id);
    return {8'hf0, 24'h070707, 8'hFD, id, 24'h0bcdef};
  endfunction
  function automatic logic [71:0] w_st(input logic [7:0] id);
    return {8'h11, 24'h070707, 8'hFD, id, 16'h5566, 8'hFB};
  endfunction
  function automatic logic [71:0] w_junk(input logic [7:0] id);
    return {8'h00, id, 56'h0123_4567_89ab_cd};
  endfunction

  task automatic push(input int src, input logic [71:0] w);
    if (src == 0) begin
      mem0[wp0[7:0]] = w;
      wp0 = wp0 + 1;
    end else begin
      mem1[wp1[7:0]] = w;
      wp1 = wp1 + 1;
    end
  endtask

  task automatic expect_w(input logic [71:0] w, input logic [1:0] g, input bit cg);
    exp_t e;
    e.w = w;
    e.g = g;
    e.cg = cg;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input int src, input logic [7:0] id, input int ndata, input bit track);
    logic [1:0] g;
    g = (src == 0) ? 2'b01 : 2'b10;
    push(src, w_start(id));
    if (track) expect_w(w_start(id), g, 1'b1);
    for (int k = 1; k <= ndata; k++) begin
      push(src, w_data(id, 8'(k)));
      if (track) expect_w(w_data(id, 8'(k)), g, 1'b1);
    end
    push(src, w_term(id));
    if (track) expect_w(w_term(id), 2'b00, 1'b1);
  endtask

  task automatic wait_exp(input string tag, input int budget, input int target);
    int n;
    n = 0;
    while ((exp_q.size() > target) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 72'(n >= budget), 72'h0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_empty(input string tag, input int src, input int budget);
    int n;
    n = 0;
    while (((src == 0) ? !e0 : !e1) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 72'(n >= budget), 72'h0);
  endtask

  // Output monitor: every non-idle word must be the next scoreboard entry.
  always @(negedge clk) begin : mon
    exp_t e;
    if (mon_en && (txd !== IDLE_W)) begin
      if (exp_q.size() == 0) begin
        chk("txd_unexpected", txd, IDLE_W);
      end else begin
        e = exp_q.pop_front();
        chk("txd", txd, e.w);
        if (e.cg) chk("grant", 72'(grant), 72'(e.g));
      end
    end
    if (grant == 2'b01) chk("rd1_nonowner", 72'(rd1), 72'h0);
    if (grant == 2'b10) chk("rd0_nonowner", 72'(rd0), 72'h0);
    if (txd === IDLE_W) begin
      idle_run <= idle_run + 1;
    end else begin
      if (txd[64] && (txd[7:0] == 8'hFB)) gaps_q.push_back(idle_run);
      idle_run <= 0;
    end
  end

  initial begin
    int g;
    rst   = 1'b1;
    tx_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_txd", txd, IDLE_W);
    chk("rst_grant", 72'(grant), 72'h0);
    chk("rst_frame", 72'(frame_cnt), 72'h0);
    chk("rst_under", 72'(under_cnt), 72'h0);
    chk("rst_drop", 72'(drop_cnt), 72'h0);
    push(0, w_junk(8'hee));
    tx_en = 1'b1;
    #1 chk("rst_rd0", 72'(rd0), 72'h0);
    @(negedge clk);
    chk("rst_hold_drop", 72'(drop_cnt), 72'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_purge_drop", 72'(drop_cnt), 72'h1);
    chk("post_rst_purge_empty", 72'(e0), 72'h1);

    // single frame on fifo0
    send_frame(0, 8'ha0, 3, 1'b1);
    wait_exp("single", 60, 0);
    chk("single_frame_cnt", 72'(frame_cnt), 72'h1);

    // both FIFOs with two frames each, fresh arbitration history
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    gaps_q.delete();
    send_frame(0, 8'hb0, 1, 1'b1);
    send_frame(1, 8'hc0, 2, 1'b1);
    send_frame(0, 8'hd0, 0, 1'b1);
    push(1, w_st(8'he0));
    expect_w(w_st(8'he0), 2'b00, 1'b0);
    wait_exp("rr", 100, 0);
    chk("rr_frame_cnt", 72'(frame_cnt), 72'h4);
    chk("rr_starts", 72'(gaps_q.size()), 72'h4);
    if (gaps_q.size() == 4) begin
      g = gaps_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        g = gaps_q.pop_front();
        chk("rr_gap", 72'(g), 72'h1);
      end
    end

    // underrun on fifo1
    push(1, w_start(8'hf0));
    push(1, w_data(8'hf0, 8'h01));
    expect_w(w_start(8'hf0), 2'b10, 1'b1);
    expect_w(w_data(8'hf0, 8'h01), 2'b10, 1'b1);
    expect_w(ABORT_W, 2'b10, 1'b1);
    repeat (10) @(negedge clk);
    chk("ur_under_early", 72'(under_cnt), 72'h1);
    push(1, w_data(8'hf0, 8'h02));
    push(1, w_term(8'hf0));
    wait_empty("ur_flush", 1, 40);
    repeat (3) @(negedge clk);
    chk("ur_under", 72'(under_cnt), 72'h1);
    chk("ur_frame_cnt", 72'(frame_cnt), 72'h4);
    chk("ur_drop", 72'(drop_cnt), 72'h0);
    chk("ur_grant", 72'(grant), 72'h0);
    chk("ur_scoreboard", 72'(exp_q.size()), 72'h0);

    // tx_en gating
    tx_en = 1'b0;
    send_frame(0, 8'h70, 2, 1'b1);
    send_frame(1, 8'h71, 1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("txoff_rd0", 72'(rd0), 72'h0);
      chk("txoff_rd1", 72'(rd1), 72'h0);
      chk("txoff_txd", txd, IDLE_W);
    end
    tx_en = 1'b1;
    #1 chk("txon_rd0", 72'(rd0), 72'h1);
    chk("txon_rd1", 72'(rd1), 72'h0);
    @(negedge clk);
    chk("txon_grant", 72'(grant), 72'h1);
    tx_en = 1'b0;
    wait_empty("txoff_mid", 0, 40);
    repeat (4) @(negedge clk);
    chk("txoff_mid_frame_cnt", 72'(frame_cnt), 72'h5);
    chk("txoff_mid_pending", 72'(exp_q.size()), 72'h3);
    chk("txoff_mid_fifo1_held", 72'(e1), 72'h0);
    tx_en = 1'b1;
    wait_exp("txon2", 60, 0);
    chk("txon2_frame_cnt", 72'(frame_cnt), 72'h6);

    // purge of non-start heads, then saturation
    push(0, w_junk(8'h01));
    push(0, w_junk(8'h02));
    push(0, w_junk(8'h03));
    send_frame(0, 8'h90, 1, 1'b1);
    wait_exp("purge", 60, 0);
    chk("purge_drop", 72'(drop_cnt), 72'h3);
    chk("purge_frame_cnt", 72'(frame_cnt), 72'h7);
    force dut.drop_cnt_q = 16'hfffe;
    #1 release dut.drop_cnt_q;
    push(0, w_junk(8'h04));
    push(1, w_junk(8'h05));
    @(negedge clk);
    chk("drop_sat2", 72'(drop_cnt), 72'hffff);
    push(0, w_junk(8'h06));
    @(negedge clk);
    chk("drop_sat1", 72'(drop_cnt), 72'hffff);

    // reset mid-frame
    mon_en = 1'b0;
    send_frame(0, 8'h40, 4, 1'b0);
    repeat (3) @(negedge clk);
    chk("mid_txd", txd, w_data(8'h40, 8'h02));
    chk("mid_grant", 72'(grant), 72'h1);
    #2 rst = 1'b1;
    #1 chk("mid_rst_txd", txd, IDLE_W);
    chk("mid_rst_grant", 72'(grant), 72'h0);
    chk("mid_rst_frame", 72'(frame_cnt), 72'h0);
    chk("mid_rst_under", 72'(under_cnt), 72'h0);
    chk("mid_rst_drop", 72'(drop_cnt), 72'h0);
    chk("mid_rst_rd0", 72'(rd0), 72'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("residue_drop", 72'(drop_cnt), 72'h3);
    chk("residue_empty", 72'(e0), 72'h1);
    mon_en = 1'b1;
    send_frame(0, 8'h50, 1, 1'b1);
    send_frame(1, 8'h51, 1, 1'b1);
    @(negedge clk);
    chk("post_rst_tie_grant", 72'(grant), 72'h1);
    wait_exp("post_rst", 60, 0);
    chk("post_rst_frame_cnt", 72'(frame_cnt), 72'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
